// File: rtl/ocra1_dac_ser.sv
// Four-channel 24-bit DAC serializer for the OCRA1 gradient board: shared SCLK/SYNC_n, optional LDAC_n pulse.
// Optional build macro OCRA1_XFER_COUNT_EN adds xfer_count_o, a count of completed transfers.
module ocra1_dac_ser #(
    parameter int SPI_DIV  = 1,
    parameter int LDAC_LEN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] data_x_i,
    input  logic [23:0] data_y_i,
    input  logic [23:0] data_z_i,
    input  logic [23:0] data_z2_i,
    input  logic        valid_i,
    input  logic        ldac_i,
    output logic        busy_o,
    output logic        ovf_o,
    output logic        oc1_clk_o,
    output logic        oc1_syncn_o,
    output logic        oc1_ldacn_o,
    output logic        oc1_sdox_o,
    output logic        oc1_sdoy_o,
    output logic        oc1_sdoz_o,
    output logic        oc1_sdoz2_o
`ifdef OCRA1_XFER_COUNT_EN
    ,
    output logic [31:0] xfer_count_o
`endif
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, LDAC} state_t;

    localparam logic [7:0] DIV_LAST  = 8'(SPI_DIV - 1);
    localparam logic [3:0] LDAC_LAST = 4'(LDAC_LEN - 1);

    state_t            state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic [4:0]        bit_q, bit_d;
    logic [3:0]        lcnt_q, lcnt_d;
    // Only the 23 not-yet-presented bits are kept; bit 23 goes straight to sdo at accept.
    logic [3:0][22:0]  sh_q, sh_d;
    logic [3:0]        sdo_q, sdo_d;
    logic              ldac_q, ldac_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              sclk_q, sclk_d;
    logic              syncn_q, syncn_d;
    logic              ldacn_q, ldacn_d;
    logic              done;
    logic              div_last;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        lcnt_d   = lcnt_q;
        sh_d     = sh_q;
        sdo_d    = sdo_q;
        ldac_d   = ldac_q;
        busy_d   = busy_q;
        sclk_d   = sclk_q;
        syncn_d  = syncn_q;
        ldacn_d  = ldacn_q;
        done     = 1'b0;
        ovf_d    = valid_i & busy_q;
        div_last = (div_q == DIV_LAST);

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    sh_d    = {data_z2_i[22:0], data_z_i[22:0], data_y_i[22:0], data_x_i[22:0]};
                    sdo_d   = {data_z2_i[23], data_z_i[23], data_y_i[23], data_x_i[23]};
                    ldac_d  = ldac_i;
                    busy_d  = 1'b1;
                    syncn_d = 1'b0;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_last) begin
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (!div_last) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_q == 5'd23) begin
                        syncn_d = 1'b1;
                        sdo_d   = '0;
                        state_d = GAP;
                    end else begin
                        // Next bit launches with the rising SCLK edge; DAC samples on the falling one.
                        bit_d  = bit_q + 5'd1;
                        sclk_d = 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            sdo_d[i] = sh_q[i][22];
                            sh_d[i]  = {sh_q[i][21:0], 1'b0};
                        end
                    end
                end
            end
            GAP: begin
                if (!div_last) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = '0;
                    if (ldac_q) begin
                        ldacn_d = 1'b0;
                        lcnt_d  = '0;
                        state_d = LDAC;
                    end else begin
                        busy_d  = 1'b0;
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            LDAC: begin
                if (lcnt_q == LDAC_LAST) begin
                    ldacn_d = 1'b1;
                    busy_d  = 1'b0;
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    lcnt_d = lcnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            lcnt_q  <= '0;
            sh_q    <= '0;
            sdo_q   <= '0;
            ldac_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            sclk_q  <= 1'b0;
            syncn_q <= 1'b1;
            ldacn_q <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            lcnt_q  <= lcnt_d;
            sh_q    <= sh_d;
            sdo_q   <= sdo_d;
            ldac_q  <= ldac_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            sclk_q  <= sclk_d;
            syncn_q <= syncn_d;
            ldacn_q <= ldacn_d;
        end
    end

`ifdef OCRA1_XFER_COUNT_EN
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (done) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign xfer_count_o = count_q;
`else
    logic unused_done;
    assign unused_done = done;
`endif

    assign busy_o      = busy_q;
    assign ovf_o       = ovf_q;
    assign oc1_clk_o   = sclk_q;
    assign oc1_syncn_o = syncn_q;
    assign oc1_ldacn_o = ldacn_q;
    assign oc1_sdox_o  = sdo_q[0];
    assign oc1_sdoy_o  = sdo_q[1];
    assign oc1_sdoz_o  = sdo_q[2];
    assign oc1_sdoz2_o = sdo_q[3];

endmodule

// File: tb/tb_ocra1_dac_ser.sv
// Bench for ocra1_dac_ser: SPI_DIV=1 and SPI_DIV=3 instances, expected transfers queued, monitor checks each completed transfer.
module tb_ocra1_dac_ser;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid1, valid3, ldac;
    logic [23:0] dx, dy, dz, dz2;
    logic busy1, ovf1, sclk1, syncn1, ldacn1, sx1, sy1, sz1, sz21;
    logic busy3, ovf3, sclk3, syncn3, ldacn3, sx3, sy3, sz3, sz23;
`ifdef OCRA1_XFER_COUNT_EN
    logic [31:0] cnt1, cnt3;
`endif

    ocra1_dac_ser #(.SPI_DIV(1), .LDAC_LEN(2)) u1 (
        .clk(clk), .rst(rst), .data_x_i(dx), .data_y_i(dy), .data_z_i(dz), .data_z2_i(dz2),
        .valid_i(valid1), .ldac_i(ldac), .busy_o(busy1), .ovf_o(ovf1), .oc1_clk_o(sclk1),
        .oc1_syncn_o(syncn1), .oc1_ldacn_o(ldacn1), .oc1_sdox_o(sx1), .oc1_sdoy_o(sy1),
        .oc1_sdoz_o(sz1), .oc1_sdoz2_o(sz21)
`ifdef OCRA1_XFER_COUNT_EN
        , .xfer_count_o(cnt1)
`endif
    );

    ocra1_dac_ser #(.SPI_DIV(3), .LDAC_LEN(2)) u3 (
        .clk(clk), .rst(rst), .data_x_i(dx), .data_y_i(dy), .data_z_i(dz), .data_z2_i(dz2),
        .valid_i(valid3), .ldac_i(ldac), .busy_o(busy3), .ovf_o(ovf3), .oc1_clk_o(sclk3),
        .oc1_syncn_o(syncn3), .oc1_ldacn_o(ldacn3), .oc1_sdox_o(sx3), .oc1_sdoy_o(sy3),
        .oc1_sdoz_o(sz3), .oc1_sdoz2_o(sz23)
`ifdef OCRA1_XFER_COUNT_EN
        , .xfer_count_o(cnt3)
`endif
    );

    logic       sel;
    logic       m_busy, m_ovf, m_sclk, m_syncn, m_ldacn;
    logic [3:0] m_sdo;
    assign m_busy  = sel ? busy3  : busy1;
    assign m_ovf   = sel ? ovf3   : ovf1;
    assign m_sclk  = sel ? sclk3  : sclk1;
    assign m_syncn = sel ? syncn3 : syncn1;
    assign m_ldacn = sel ? ldacn3 : ldacn1;
    assign m_sdo   = sel ? {sz23, sz3, sy3, sx3} : {sz21, sz1, sy1, sx1};

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [23:0] w[4];
        int div, syncn_lo, sclk_hi, busy_cyc, ldac_lo, ldac_first, ovf_cnt, ovf_first;
        bit abort;
    } exp_t;
    exp_t q[$];

    function automatic exp_t mk(input logic [23:0] a, b, c, d, input int s, input bit l,
                                input int ovc, input int ovfirst, input bit ab);
        exp_t e;
        e.w[0] = a; e.w[1] = b; e.w[2] = c; e.w[3] = d;
        e.div        = s;
        e.syncn_lo   = 49 * s;
        e.sclk_hi    = 24 * s;
        e.busy_cyc   = 50 * s + (l ? 2 : 0);
        e.ldac_lo    = l ? 2 : 0;
        e.ldac_first = l ? 50 * s : -1;
        e.ovf_cnt    = ovc;
        e.ovf_first  = ovfirst;
        e.abort      = ab;
        return e;
    endfunction

    // Monitor: accumulates per-transfer observations, compares against the queue when busy falls.
    int idx, c_sync, c_sclk, c_busy, c_ldac, ldac_first, c_ovf, ovf_first, nfall, bad_run, run;
    logic [23:0] got[4];
    logic p_busy = 1'b0;
    logic p_sclk = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (m_busy === 1'b1 && p_busy !== 1'b1) begin
            idx = 0; c_sync = 0; c_sclk = 0; c_busy = 0; c_ldac = 0; ldac_first = -1;
            c_ovf = 0; ovf_first = -1; nfall = 0; bad_run = 0; run = 0;
            for (int i = 0; i < 4; i++) got[i] = '0;
        end else begin
            idx++;
        end
        if (m_syncn === 1'b0) c_sync++;
        if (m_sclk === 1'b1) begin c_sclk++; run++; end
        if (m_busy === 1'b1) c_busy++;
        if (m_ldacn === 1'b0) begin
            if (c_ldac == 0) ldac_first = idx;
            c_ldac++;
        end
        if (m_ovf === 1'b1) begin
            if (c_ovf == 0) ovf_first = idx;
            c_ovf++;
        end
        if (p_sclk === 1'b1 && m_sclk === 1'b0) begin
            nfall++;
            for (int i = 0; i < 4; i++) got[i] = {got[i][22:0], m_sdo[i]};
            if (run != (sel ? 3 : 1)) bad_run++;
            run = 0;
        end
        if (m_busy === 1'b0 && p_busy === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_xfer", q.size(), 1);
            end else begin
                e = q.pop_front();
                check("sdo_idle", m_sdo, 0);
                if (e.abort) begin
                    check("abort_ldac_lo", c_ldac, 0);
                end else begin
                    check("word_x", got[0], e.w[0]);
                    check("word_y", got[1], e.w[1]);
                    check("word_z", got[2], e.w[2]);
                    check("word_z2", got[3], e.w[3]);
                    check("sclk_falls", nfall, 24);
                    check("sclk_run", bad_run, 0);
                    check("sclk_hi", c_sclk, e.sclk_hi);
                    check("syncn_lo", c_sync, e.syncn_lo);
                    check("busy_cyc", c_busy, e.busy_cyc);
                    check("ldac_lo", c_ldac, e.ldac_lo);
                    check("ldac_first", ldac_first, e.ldac_first);
                    check("ovf_cnt", c_ovf, e.ovf_cnt);
                    check("ovf_first", ovf_first, e.ovf_first);
                end
            end
        end
        p_busy = m_busy;
        p_sclk = m_sclk;
    end

    task automatic go(input logic [23:0] a, b, c, d, input bit l);
        @(negedge clk);
        dx = a; dy = b; dz = c; dz2 = d; ldac = l; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        check("accept", m_busy, 1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (m_busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_in_time", (n < 5000), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        sel = 1'b0; rst = 1'b1; valid1 = 1'b1; valid3 = 1'b1; ldac = 1'b1;
        dx = 24'hFFFFFF; dy = 24'hFFFFFF; dz = 24'hFFFFFF; dz2 = 24'hFFFFFF;
        repeat (3) begin
            @(negedge clk);
            check("reset_out", {busy1, ovf1, sclk1, syncn1, ldacn1, sx1, sy1, sz1, sz21}, 9'b000110000);
        end
        rst = 1'b0; valid1 = 1'b0; valid3 = 1'b0;

        q.push_back(mk(24'hA5A5A5, 24'h5A5A5A, 24'h800000, 24'h000001, 1, 1'b1, 0, -1, 1'b0));
        go(24'hA5A5A5, 24'h5A5A5A, 24'h800000, 24'h000001, 1'b1);
        wait_idle(n);
        check("lat_ldac1", n, 52);

        q.push_back(mk(24'hA5A5A5, 24'h5A5A5A, 24'h800000, 24'h000001, 1, 1'b0, 0, -1, 1'b0));
        go(24'hA5A5A5, 24'h5A5A5A, 24'h800000, 24'h000001, 1'b0);
        wait_idle(n);
        check("lat_ldac0", n, 50);

        // Requests in cycles 10 and 11 must be dropped and reported one cycle later.
        q.push_back(mk(24'h5A5A5A, 24'hA5A5A5, 24'h000001, 24'h800000, 1, 1'b1, 2, 11, 1'b0));
        go(24'h5A5A5A, 24'hA5A5A5, 24'h000001, 24'h800000, 1'b1);
        repeat (10) @(negedge clk);
        dx = 24'h111111; dy = 24'h222222; dz = 24'h333333; dz2 = 24'h444444; valid1 = 1'b1;
        repeat (2) @(negedge clk);
        valid1 = 1'b0;
        wait_idle(n);

        q.push_back(mk(24'h0, 24'h0, 24'h0, 24'h0, 1, 1'b1, 0, -1, 1'b1));
        go(24'h123456, 24'h789ABC, 24'hDEF012, 24'h345678, 1'b1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out", {busy1, sclk1, syncn1, ldacn1}, 4'b0011);
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (ldacn1 !== 1'b1) seen = 1'b1;
        end
        check("abort_no_ldac", seen, 0);

        q.push_back(mk(24'h123456, 24'hFEDCBA, 24'h000000, 24'hFFFFFF, 1, 1'b0, 0, -1, 1'b0));
        go(24'h123456, 24'hFEDCBA, 24'h000000, 24'hFFFFFF, 1'b0);
        wait_idle(n);
        check("lat_fresh", n, 50);

        // SPI_DIV=3, valid held through the first transfer so the second starts immediately.
        sel = 1'b1;
        @(negedge clk);
        q.push_back(mk(24'hC3C3C3, 24'h0F0F0F, 24'h7FFFFF, 24'h000002, 3, 1'b1, 152, 1, 1'b0));
        q.push_back(mk(24'h3C3C3C, 24'hF0F0F0, 24'h800001, 24'hABCDEF, 3, 1'b1, 0, -1, 1'b0));
        dx = 24'hC3C3C3; dy = 24'h0F0F0F; dz = 24'h7FFFFF; dz2 = 24'h000002; ldac = 1'b1; valid3 = 1'b1;
        @(negedge clk);
        check("b2b_accept1", busy3, 1);
        dx = 24'h3C3C3C; dy = 24'hF0F0F0; dz = 24'h800001; dz2 = 24'hABCDEF;
        wait_idle(n);
        check("b2b_lat1", n, 152);
        @(negedge clk);
        check("b2b_accept2", busy3, 1);
        valid3 = 1'b0;
        wait_idle(n);
        check("b2b_lat2", n, 152);
`ifdef OCRA1_XFER_COUNT_EN
        check("xfer_count3", cnt3, 2);
        check("xfer_count1", cnt1, 1);
`endif
        repeat (3) @(negedge clk);
        check("sb_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
